fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

FIFO-draining UART transmitter. Sits on the read side of a synchronous FIFO and serializes each entry into an asynchronous serial frame on `tx`. The FIFO read port presents data while not empty and advances one cycle after a read-enable cycle. This block pops exactly one entry per frame and sends frames back-to-back while data remains.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9; also the width of the FIFO data port.
- `BAUD_DIV`, 868: clock cycles per serial bit, ≥ 2 (868 gives 115200 baud at 100 MHz).
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk` in 1: main clock.
- `rst_n` in 1: synchronous reset, active-low.
- `en` in 1: transmit enable; low means no new frame starts, and a frame in progress completes.
- `fifo_data` in DATA_BITS: FIFO read data, valid whenever `fifo_empty` = 0.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_en_r` out 1: FIFO read enable, a single-cycle pop pulse.
- `tx` out 1: serial line, idles high.
- `busy` out 1: high from the frame-start edge through the end of the last stop bit.
- `frame_done` out 1: one-cycle pulse in the last cycle of the last stop bit.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PARITY (skipped when `PARITY` = 0)
  - STOP
- All outputs are registered.
- Reset values: `tx` = 1, `fifo_en_r` = 0, `busy` = 0, `frame_done` = 0, state = IDLE, baud counter = 0, bit index = 0.
- Frame start, on an edge where state = IDLE and `en` = 1 and `fifo_empty` = 0:
  - shift register <= `fifo_data`;
  - `fifo_en_r` <= 1, for one cycle only;
  - `tx` <= 0, state <= START, `busy` <= 1, baud counter <= BAUD_DIV-1.
  - The parity accumulator is computed from the latched word: odd makes the total count of ones (data plus parity bit) odd; even makes it even.
- Bit timing: every bit holds `tx` for exactly BAUD_DIV cycles. The counter decrements each cycle. At 0 it reloads to BAUD_DIV-1 and advances to the next bit.
- Order on the line:
  1. start bit (0);
  2. data, LSB first, `DATA_BITS` bits;
  3. optional parity bit;
  4. `STOP_BITS` stop bits (1).
- End of the last stop bit (counter = 0), with `frame_done` asserted this cycle:
  - If `en` = 1 and `fifo_empty` = 0, start the next frame on the same edge, with no idle gap: `tx` goes 1→0, `fifo_en_r` pulses, `busy` stays 1.
  - Otherwise: state <= IDLE, `busy` <= 0, `tx` stays 1.
- `fifo_empty` and `fifo_data` are sampled only at a frame start. The FIFO's one-cycle post-pop update is therefore always settled before the next sample (a frame is ≥ 4·BAUD_DIV ≥ 8 cycles).
- `fifo_en_r` is never asserted while `fifo_empty` = 1 and never in two consecutive cycles.
- Deasserting `en` mid-frame does not truncate the frame.
- `rst_n` low mid-frame: at the next edge all outputs take their reset values and `tx` goes high immediately. The partial frame is abandoned. The popped word is lost, and no further pop occurs.
- Simultaneous `rst_n` low and a start condition: reset wins, and no pop occurs.

## Timing
- Latency: a start condition sampled at edge N gives `tx` = 0 and `fifo_en_r` = 1 during cycle N..N+1.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) · BAUD_DIV cycles.
- Sustained throughput with a non-empty FIFO: one frame per frame length, one pop per frame.
- `busy` falls at the same edge `tx` would start an idle period. `frame_done` is high in exactly one cycle per completed frame; frames abandoned by reset produce no pulse.

## Test plan
- 8N1, BAUD_DIV=4, FIFO holds 0x55:
  - `tx` reads 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total).
  - One `fifo_en_r` pulse, coincident with the start-bit edge.
  - `frame_done` in cycle 40; then `busy` = 0 and `tx` = 1.
- Back-to-back: FIFO holds 0xA3, 0x0F, BAUD_DIV=4, 8N1:
  - 80 contiguous frame cycles with no idle bit between frames.
  - Two `fifo_en_r` pulses exactly 40 cycles apart.
  - LSB-first bit patterns match.
- Parity, DATA_BITS=7, 2 stop bits:
  - PARITY=2 (even), 0x41: parity bit 0.
  - PARITY=1 (odd), 0x41: parity bit 1.
  - Frame length 11·BAUD_DIV.
- Empty FIFO: `fifo_empty` held 1 for 100 cycles → `tx` = 1, `fifo_en_r` never asserted, `busy` = 0.
- Enable gating:
  - `en` dropped mid-frame with data still queued: the current frame completes, then IDLE with no pop.
  - `en` raised again: the next frame starts on the following edge.
- Reset mid-frame: `rst_n` = 0 during the DATA state:
  - Next edge gives `tx` = 1, `busy` = 0, `fifo_en_r` = 0, no `frame_done` pulse.
  - After release with a non-empty FIFO, a fresh full frame is sent.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO, popping one entry per frame
// and sending frames back-to-back while data remains and transmit is enabled.
module fifo_uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_DIV  = 868,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DATA_BITS-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_en_r,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 pop_q, pop_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic start_ok, tick, last_stop, load;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pop_d     = 1'b0;
    load      = 1'b0;
    start_ok  = en && !fifo_empty;
    tick      = (cnt_q == '0);
    last_stop = (state_q == S_STOP) && (bit_q == 4'(STOP_BITS - 1));
    // Registered pulse: raised on the edge entering the final cycle of the last stop bit.
    done_d    = last_stop && (cnt_q == CW'(1));

    if (state_q != S_IDLE) cnt_d = tick ? CNT_MAX : cnt_q - CW'(1);

    case (state_q)
      S_IDLE: begin
        if (start_ok) load = 1'b1;
      end
      S_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 4'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              bit_d   = '0;
              state_d = S_STOP;
            end
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (last_stop) begin
            if (start_ok) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
              cnt_d   = '0;
              bit_d   = '0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shift_d = fifo_data;
      par_d   = (PARITY == 1) ? ~^fifo_data : ^fifo_data;
      pop_d   = 1'b1;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      cnt_d   = CNT_MAX;
      bit_d   = '0;
      state_d = S_START;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_en_r  = pop_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: 8N1 single/back-to-back frames, empty FIFO,
// enable gating, mid-frame reset, and 7-bit even/odd parity with two stop bits.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // 8N1 DUT fed by a small FIFO model.
  logic       rst_n, en;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_en_r, tx, busy, frame_done;

  logic [7:0] mem [0:7];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr % 8];

  always @(posedge clk) if (fifo_en_r && !fifo_empty) rd_ptr <= rd_ptr + 1;

  fifo_uart_tx #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_en_r(fifo_en_r), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  // 7E2 and 7O2 DUTs sharing one stimulus.
  logic       p_en, p_empty;
  logic [6:0] p_data;
  logic       e_pop, e_tx, e_busy, e_done;
  logic       o_pop, o_tx, o_busy, o_done;

  fifo_uart_tx #(.DATA_BITS(7), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(2)) u_even (
    .clk(clk), .rst_n(rst_n), .en(p_en), .fifo_data(p_data), .fifo_empty(p_empty),
    .fifo_en_r(e_pop), .tx(e_tx), .busy(e_busy), .frame_done(e_done)
  );

  fifo_uart_tx #(.DATA_BITS(7), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(2)) u_odd (
    .clk(clk), .rst_n(rst_n), .en(p_en), .fifo_data(p_data), .fifo_empty(p_empty),
    .fifo_en_r(o_pop), .tx(o_tx), .busy(o_busy), .frame_done(o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 8] = d;
    wr_ptr++;
  endtask

  // Checks one 40-cycle 8N1 frame starting at the next edge; optionally drops en mid-frame.
  task automatic frame_check(input logic [7:0] d, input int drop_at);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("tx[%0h:%0d]", d, i), tx, f[i / 4]);
      chk($sformatf("pop[%0h:%0d]", d, i), fifo_en_r, (i == 0));
      chk($sformatf("done[%0h:%0d]", d, i), frame_done, (i == 39));
      chk($sformatf("busy[%0h:%0d]", d, i), busy, 1'b1);
      if (i == drop_at) en = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_tx[%0d]", tag, i), tx, 1'b1);
      chk($sformatf("%s_busy[%0d]", tag, i), busy, 1'b0);
      chk($sformatf("%s_pop[%0d]", tag, i), fifo_en_r, 1'b0);
    end
  endtask

  logic [10:0] pf_e, pf_o;

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    p_en    = 1'b1;
    p_empty = 1'b1;
    p_data  = 7'h41;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pop", fifo_en_r, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_etx", e_tx, 1'b1);
    chk("rst_otx", o_tx, 1'b1);
    rst_n = 1'b1;

    // Empty FIFO for 100 cycles with en high
    idle_check("empty", 100);

    // Single frame 0x55
    push(8'h55);
    frame_check(8'h55, -1);
    idle_check("after55", 3);

    // Back-to-back 0xA3, 0x0F
    push(8'hA3);
    push(8'h0F);
    frame_check(8'hA3, -1);
    frame_check(8'h0F, -1);
    idle_check("afterb2b", 3);

    // Enable dropped mid-frame with data queued, then raised again
    push(8'h11);
    push(8'h22);
    push(8'h33);
    frame_check(8'h11, 20);
    idle_check("gated", 10);
    chk("gated_fifo_nonempty", fifo_empty, 1'b0);
    en = 1'b1;
    frame_check(8'h22, -1);
    frame_check(8'h33, -1);
    idle_check("afteren", 3);

    // Reset during DATA: 0x5A abandoned, 0xC3 sent fresh after release
    push(8'h5A);
    push(8'hC3);
    repeat (15) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mrst_tx[%0d]", i), tx, 1'b1);
      chk($sformatf("mrst_busy[%0d]", i), busy, 1'b0);
      chk($sformatf("mrst_pop[%0d]", i), fifo_en_r, 1'b0);
      chk($sformatf("mrst_done[%0d]", i), frame_done, 1'b0);
    end
    rst_n = 1'b1;
    frame_check(8'hC3, -1);
    idle_check("afterrst", 3);

    // 7-bit parity frames, two stop bits: 0x41 has two ones
    pf_e = {2'b11, 1'b0, 7'h41, 1'b0};
    pf_o = {2'b11, 1'b1, 7'h41, 1'b0};
    p_empty = 1'b0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      if (i == 0) p_empty = 1'b1;
      chk($sformatf("even_tx[%0d]", i), e_tx, pf_e[i / 4]);
      chk($sformatf("odd_tx[%0d]", i), o_tx, pf_o[i / 4]);
      chk($sformatf("even_pop[%0d]", i), e_pop, (i == 0));
      chk($sformatf("odd_done[%0d]", i), o_done, (i == 43));
      chk($sformatf("even_done[%0d]", i), e_done, (i == 43));
      chk($sformatf("odd_busy[%0d]", i), o_busy, 1'b1);
    end
    @(negedge clk);
    chk("even_end_busy", e_busy, 1'b0);
    chk("odd_end_busy", o_busy, 1'b0);
    chk("odd_end_tx", o_tx, 1'b1);
    chk("odd_end_pop", o_pop, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
